// File: rtl/red_pkg.sv
// red_pkg: shared state encoding and default widths for the red_seq reduction unit
package red_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANE_W = 8;
  typedef enum logic [1:0] {IDLE, SUM, DONE} red_state_t;
endpackage

// File: rtl/red_lane_ext.sv
// red_lane_ext: sign- or zero-extends one LANE_W lane to DATA_W
module red_lane_ext #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] lane,
  input  logic              mode_signed,
  output logic [DATA_W-1:0] ext
);
  always_comb ext = mode_signed ? DATA_W'($signed(lane)) : DATA_W'(lane);
endmodule

// File: rtl/red_seq.sv
// red_seq: multi-cycle lane reduction, one rs/rt lane pair per clock, optional accumulator
module red_seq
  import red_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic              mode_signed,
  input  logic              accum,
  input  logic              clr_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rd,
  output logic              busy
);
  localparam int NLANES = DATA_W / LANE_W;
  localparam int KW = NLANES > 1 ? $clog2(NLANES) : 1;

  red_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d, partial_q, partial_d, acc_q, acc_d;
  logic [DATA_W-1:0] rs_ext, rt_ext;
  logic sgn_q, sgn_d, accept, last;

  red_lane_ext #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_ext_rs (
    .lane(rs_q[LANE_W-1:0]), .mode_signed(sgn_q), .ext(rs_ext)
  );
  red_lane_ext #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_ext_rt (
    .lane(rt_q[LANE_W-1:0]), .mode_signed(sgn_q), .ext(rt_ext)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    accept = in_valid && state_q == IDLE;
    last = k_q == KW'(NLANES - 1);
    state_d = state_q == IDLE ? (in_valid ? SUM : IDLE) :
              state_q == SUM  ? (last ? DONE : SUM) :
                                (out_ready ? IDLE : DONE);
  end

  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    busy = state_q != IDLE;
    rd = partial_q;
  end

  // operands shift down one lane per SUM cycle so the extenders always see lane k at bit 0
  always_comb begin
    rs_d = accept ? rs : state_q == SUM ? rs_q >> LANE_W : rs_q;
    rt_d = accept ? rt : state_q == SUM ? rt_q >> LANE_W : rt_q;
    sgn_d = accept ? mode_signed : sgn_q;
    k_d = accept ? '0 : state_q == SUM ? k_q + 1'b1 : k_q;
    partial_d = accept ? (accum && !clr_acc ? acc_q : '0) :
                state_q == SUM ? partial_q + rs_ext + rt_ext : partial_q;
    acc_d = clr_acc ? '0 : (state_q == DONE && out_ready) ? partial_q : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      sgn_q <= 1'b0;
      partial_q <= '0;
      acc_q <= '0;
    end else begin
      k_q <= k_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      sgn_q <= sgn_d;
      partial_q <= partial_d;
      acc_q <= acc_d;
    end
endmodule

// File: tb/tb_red_seq.sv
// tb_red_seq: randomized and directed checks of red_seq against an arithmetic lane-sum model
module tb_red_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, mode_signed = 0, accum = 0, clr_acc = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [15:0] rs = 0, rt = 0, rd;
  logic w_in_valid = 0, w_mode_signed = 0, w_accum = 0, w_clr_acc = 0, w_out_ready = 1;
  logic w_in_ready, w_out_valid, w_busy;
  logic [31:0] w_rs = 0, w_rt = 0, w_rd;
  int n_vec = 0, n_err = 0;
  logic [15:0] model_acc = 0;

  always #5 clk = ~clk;

  red_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .rs(rs), .rt(rt),
    .mode_signed(mode_signed), .accum(accum), .clr_acc(clr_acc), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .busy(busy));

  red_seq #(.DATA_W(32), .LANE_W(8)) dut_w (.clk(clk), .rst_n(rst_n), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .rs(w_rs), .rt(w_rt), .mode_signed(w_mode_signed), .accum(w_accum),
    .clr_acc(w_clr_acc), .out_valid(w_out_valid), .out_ready(w_out_ready), .rd(w_rd), .busy(w_busy));

  function automatic logic [63:0] model(input logic [63:0] a, b, input bit sgn,
                                        input logic [63:0] start, input int dw, lw);
    longint s, la, lb, m;
    m = (longint'(1) << lw) - 1;
    s = longint'(start);
    for (int i = 0; i < dw / lw; i++) begin
      la = longint'(a >> (i * lw)) & m;
      lb = longint'(b >> (i * lw)) & m;
      if (sgn && la > (m >> 1)) la -= m + 1;
      if (sgn && lb > (m >> 1)) lb -= m + 1;
      s += la + lb;
    end
    return 64'(s) & ((64'd1 << dw) - 1);
  endfunction

  task automatic do_accept(input logic [15:0] a, b, input bit sgn, acc, clr);
    rs = a; rt = b; mode_signed = sgn; accum = acc; clr_acc = clr; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; clr_acc = 0; accum = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (rd !== 16'h0) begin n_err++; $display("FAIL reset_rd got %h want 0000", rd); end
    #10 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [15:0] ta [9] = '{16'hFFFF, 16'h0101, 16'h007F, 16'hE300, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'h0101, 16'h0101};
    logic [15:0] tb [9] = '{16'hFFFF, 16'h1234, 16'h7F00, 16'h00E5, 16'hF200, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234};
    bit ts [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    bit tacc [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit tclr [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [15:0] texp [9] = '{16'hFFFC, 16'h0048, 16'h00FE, 16'hFFC8, 16'hFFF1, 16'h03FC, 16'hFFFC, 16'h0044, 16'h0048};
    int n;
    for (int i = 0; i < 9; i++) begin
      do_accept(ta[i], tb[i], ts[i], tacc[i], tclr[i]);
      wait_valid(n);
      n_vec++; if (n !== 2) begin n_err++; $display("FAIL vec%0d_latency got %0d want 2", i, n); end
      n_vec++; if (rd !== texp[i]) begin n_err++; $display("FAIL vec%0d_rd got %h want %h", i, rd, texp[i]); end
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
        begin n_err++; $display("FAIL vec%0d_handshake in_ready %b out_valid %b want 1 0", i, in_ready, out_valid); end
      model_acc = texp[i];
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] a, b, exp;
    int n;
    a = 16'($urandom); b = 16'($urandom);
    exp = 16'(model(64'(a), 64'(b), 1'b0, 64'(model_acc), 16, 8));
    out_ready = 0;
    do_accept(a, b, 1'b0, 1'b1, 1'b0);
    wait_valid(n);
    n_vec++; if (n !== 2) begin n_err++; $display("FAIL bp_latency got %0d want 2", n); end
    n_vec++; if (rd !== exp) begin n_err++; $display("FAIL bp_rd got %h want %h", rd, exp); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; rs = 16'($urandom); rt = 16'($urandom);
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd !== exp)
        begin n_err++; $display("FAIL bp_hold%0d out_valid %b in_ready %b rd %h want 1 0 %h", c, out_valid, in_ready, rd, exp); end
    end
    in_valid = 0; out_ready = 1; clr_acc = 1;
    @(posedge clk); #1;
    clr_acc = 0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL bp_release in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    model_acc = 0;
    do_accept(16'h0101, 16'h1234, 1'b1, 1'b1, 1'b0);
    wait_valid(n);
    n_vec++; if (rd !== 16'h0048) begin n_err++; $display("FAIL clr_on_done_rd got %h want 0048", rd); end
    @(posedge clk); #1;
    model_acc = 16'h0048;
  endtask

  task automatic test_midreset;
    logic [15:0] a, b, exp;
    int n, bad;
    do_accept(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
    #2 rst_n = 0;
    #1;
    n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rd !== 16'h0)
      begin n_err++; $display("FAIL midreset_outputs in_ready %b busy %b out_valid %b rd %h want 1 0 0 0000", in_ready, busy, out_valid, rd); end
    #2 rst_n = 1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL midreset_no_valid got %0d valid cycles want 0", bad); end
    model_acc = 0;
    a = 16'($urandom); b = 16'($urandom);
    exp = 16'(model(64'(a), 64'(b), 1'b1, 64'(model_acc), 16, 8));
    do_accept(a, b, 1'b1, 1'b1, 1'b0);
    wait_valid(n);
    n_vec++; if (n !== 2 || rd !== exp) begin n_err++; $display("FAIL midreset_next latency %0d rd %h want 2 %h", n, rd, exp); end
    @(posedge clk); #1;
    model_acc = exp;
  endtask

  task automatic test_random;
    logic [15:0] a, b, exp;
    bit sgn, acc, clr;
    int n;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      sgn = 1'($urandom_range(0, 1)); acc = 1'($urandom_range(0, 1)); clr = $urandom_range(0, 3) == 0;
      exp = 16'(model(64'(a), 64'(b), sgn, (acc && !clr) ? 64'(model_acc) : 64'd0, 16, 8));
      do_accept(a, b, sgn, acc, clr);
      wait_valid(n);
      n_vec++; if (n !== 2 || rd !== exp)
        begin n_err++; $display("FAIL rand%0d latency %0d rd %h want 2 %h", i, n, rd, exp); end
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rand%0d_ready got %b want 1", i, in_ready); end
      model_acc = exp;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_wide;
    logic [31:0] a, b, exp;
    bit sgn;
    int n;
    for (int i = 0; i < 4; i++) begin
      a = i == 0 ? 32'h01020304 : $urandom;
      b = i == 0 ? 32'h05060708 : $urandom;
      sgn = i == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      exp = i == 0 ? 32'h00000024 : 32'(model(64'(a), 64'(b), sgn, 64'd0, 32, 8));
      w_rs = a; w_rt = b; w_mode_signed = sgn; w_in_valid = 1;
      @(posedge clk); #1;
      w_in_valid = 0;
      n = 0;
      while (w_out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      n_vec++; if (n !== 4) begin n_err++; $display("FAIL wide%0d_latency got %0d want 4", i, n); end
      n_vec++; if (w_rd !== exp) begin n_err++; $display("FAIL wide%0d_rd got %h want %h", i, w_rd, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_midreset;
    test_random;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
